// File: rtl/srm_ctrl_pkg.sv
// Shared types and encodings for the simple RISC multi-cycle controller.
package srm_ctrl_pkg;

  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT    = 4'd0,
    S_DECODE  = 4'd1,
    S_WR_IMM  = 4'd2,
    S_GET_A   = 4'd3,
    S_GET_B   = 4'd4,
    S_ALU     = 4'd5,
    S_CMP     = 4'd6,
    S_WR_RD   = 4'd7,
    S_HALT    = 4'd8,
    S_ILLEGAL = 4'd9
  } ctrl_state_t;

  localparam logic [OPC_W-1:0] OPC_MOV  = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

  localparam logic [OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [OP_W-1:0] ALU_CMP = 2'b01;
  localparam logic [OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [OP_W-1:0] ALU_MVN = 2'b11;

  // MOV variants share the op field with the ALU group
  localparam logic [OP_W-1:0] MOV_REG = 2'b00;
  localparam logic [OP_W-1:0] MOV_IMM = 2'b10;

  localparam logic [SEL_W-1:0] NSEL_RM = 2'b00;
  localparam logic [SEL_W-1:0] NSEL_RD = 2'b01;
  localparam logic [SEL_W-1:0] NSEL_RN = 2'b10;

  localparam logic [SEL_W-1:0] VSEL_C     = 2'b00;
  localparam logic [SEL_W-1:0] VSEL_IMM8  = 2'b01;
  localparam logic [SEL_W-1:0] VSEL_MDATA = 2'b10;

endpackage

// File: rtl/srm_controller.sv
// Multi-cycle Moore control FSM: accepts a decoded instruction on s/w and
// sequences register-file, ALU, status and write-back strobes.
module srm_controller
  import srm_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s,
  input  logic [OPC_W-1:0] opcode,
  input  logic [OP_W-1:0]  op,
  output logic             w,
  output logic [SEL_W-1:0] nsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [SEL_W-1:0] vsel,
  output logic             write,
  output logic             done,
  output logic             halted,
  output logic             err
);

  ctrl_state_t      state_q, state_d;
  logic [OPC_W-1:0] opc_q;
  logic [OP_W-1:0]  op_q;

  // State register plus instruction latch captured only on the accept edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      opc_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT && s) begin
        opc_q <= opcode;
        op_q  <= op;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    w       = 1'b0;
    nsel    = NSEL_RM;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    vsel    = VSEL_C;
    write   = 1'b0;
    done    = 1'b0;
    halted  = 1'b0;
    err     = 1'b0;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opc_q == OPC_MOV && op_q == MOV_IMM)      state_d = S_WR_IMM;
        else if (opc_q == OPC_MOV && op_q == MOV_REG) state_d = S_GET_B;
        else if (opc_q == OPC_ALU && op_q == ALU_MVN) state_d = S_GET_B;
        else if (opc_q == OPC_ALU)                    state_d = S_GET_A;
        else if (opc_q == OPC_HALT)                   state_d = S_HALT;
        else                                          state_d = S_ILLEGAL;
      end
      S_WR_IMM: begin
        nsel    = NSEL_RN;
        vsel    = VSEL_IMM8;
        write   = 1'b1;
        done    = 1'b1;
        state_d = S_WAIT;
      end
      S_GET_A: begin
        nsel    = NSEL_RN;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        nsel    = NSEL_RM;
        loadb   = 1'b1;
        state_d = (opc_q == OPC_ALU && op_q == ALU_CMP) ? S_CMP : S_ALU;
      end
      S_ALU: begin
        // Single-operand ops pass B through by zeroing the A operand
        loadc   = 1'b1;
        asel    = (opc_q == OPC_MOV) || (op_q == ALU_MVN);
        state_d = S_WR_RD;
      end
      S_CMP: begin
        loads   = 1'b1;
        done    = 1'b1;
        state_d = S_WAIT;
      end
      S_WR_RD: begin
        nsel    = NSEL_RD;
        vsel    = VSEL_C;
        write   = 1'b1;
        done    = 1'b1;
        state_d = S_WAIT;
      end
      S_HALT: begin
        halted  = 1'b1;
      end
      S_ILLEGAL: begin
        err     = 1'b1;
        done    = 1'b1;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule
